// File: rtl/sc_sequence_counter.sv
// Control-unit sequence counter: run/halt FSM, SC step counter, sticky overrun, retired-instruction count.
// Optional registered one-hot timing output T_reg when SC_ONEHOT_OUT_EN is defined.
module sc_sequence_counter #(
  parameter int SC_W  = 4,
  parameter int MAX_T = 7,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt,
  input  logic             sc_clr,
  input  logic             stall,
  input  logic             ovr_clr,
  output logic [SC_W-1:0]  SC,
  output logic             running,
  output logic             overrun,
  output logic [CNT_W-1:0] instr_cnt
`ifdef SC_ONEHOT_OUT_EN
  ,
  output logic [MAX_T:0]   T_reg
`endif
);

  localparam logic [SC_W-1:0] MAX_SC = SC_W'(MAX_T);

  typedef enum logic [1:0] {IDLE, RUN, HALTING} state_t;

  state_t          state, state_nxt;
  logic [SC_W-1:0] sc_nxt;
  logic            ovr_set;
  logic            cnt_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !halt) state_nxt = RUN;
      RUN:     if (halt) state_nxt = sc_clr ? IDLE : HALTING;
      HALTING: if (sc_clr) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (state != IDLE);
  end

  // Step datapath; sc_clr beats stall, stall beats wrap/increment.
  always_comb begin
    sc_nxt  = SC;
    ovr_set = 1'b0;
    cnt_inc = 1'b0;
    if (state == IDLE) begin
      sc_nxt = '0;
    end else if (sc_clr) begin
      sc_nxt  = '0;
      cnt_inc = 1'b1;
    end else if (!stall) begin
      if (SC == MAX_SC) begin
        sc_nxt  = '0;
        ovr_set = 1'b1;
      end else begin
        sc_nxt = SC + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SC        <= '0;
      overrun   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      SC        <= sc_nxt;
      overrun   <= ovr_set | (overrun & ~ovr_clr);
      instr_cnt <= instr_cnt + CNT_W'(cnt_inc);
    end
  end

`ifdef SC_ONEHOT_OUT_EN
  localparam int TW = MAX_T + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) T_reg <= TW'(1);
    else        T_reg <= TW'(1) << sc_nxt;
  end
`endif

endmodule

// File: tb/tb_sc_sequence_counter.sv
// Self-checking bench for sc_sequence_counter: directed test-plan scenarios plus
// randomized traffic against a behavioural model of the run/halt/step rules.
module tb_sc_sequence_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, halt = 1'b0, sc_clr = 1'b0, stall = 1'b0, ovr_clr = 1'b0;
  logic [3:0]  sc;
  logic        running, overrun;
  logic [15:0] instr_cnt;
`ifdef SC_ONEHOT_OUT_EN
  logic [7:0]  t_reg;
`endif

  int checks = 0;
  int errors = 0;

  // Model state: mode 0=idle, 1=run, 2=halting.
  int          m_mode;
  int          m_sc;
  bit          m_ovr;
  int unsigned m_cnt;

  sc_sequence_counter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt), .sc_clr(sc_clr),
    .stall(stall), .ovr_clr(ovr_clr), .SC(sc), .running(running),
    .overrun(overrun), .instr_cnt(instr_cnt)
`ifdef SC_ONEHOT_OUT_EN
    , .T_reg(t_reg)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_mode = 0; m_sc = 0; m_ovr = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    bit wrap = 0;
    if (m_mode != 0) begin
      if (sc_clr) begin
        m_sc = 0;
        m_cnt = (m_cnt + 1) % 65536;
      end else if (!stall) begin
        if (m_sc == 7) begin m_sc = 0; wrap = 1; end
        else m_sc = m_sc + 1;
      end
    end
    if (wrap) m_ovr = 1;
    else if (ovr_clr) m_ovr = 0;
    case (m_mode)
      0: if (start && !halt) m_mode = 1;
      1: if (halt) m_mode = sc_clr ? 0 : 2;
      default: if (sc_clr) m_mode = 0;
    endcase
  endtask

  task automatic cycle(input bit s, input bit h, input bit c, input bit st, input bit oc);
    start = s; halt = h; sc_clr = c; stall = st; ovr_clr = oc;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 0; halt = 0; sc_clr = 0; stall = 0; ovr_clr = 0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (sc !== 4'd0 || running !== 1'b0 || overrun !== 1'b0 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: sc=%0d run=%0b ovr=%0b cnt=%0d expected all 0", sc, running, overrun, instr_cnt);
    end
  endtask

  task automatic test_count_wrap();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    checks++;
    if (running !== 1'b1 || sc !== 4'd0) begin
      errors++;
      $display("FAIL start: run=%0b sc=%0d expected run=1 sc=0", running, sc);
    end
    for (int i = 1; i <= 7; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (sc !== 4'(i) || overrun !== 1'b0) begin
        errors++;
        $display("FAIL count: sc=%0d ovr=%0b expected sc=%0d ovr=0", sc, overrun, i);
      end
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (sc !== 4'd0 || overrun !== 1'b1 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL wrap: sc=%0d ovr=%0b cnt=%0d expected sc=0 ovr=1 cnt=0", sc, overrun, instr_cnt);
    end
  endtask

  task automatic test_sc_clr();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      repeat (3) cycle(0, 0, 0, 0, 0);
      checks++;
      if (sc !== 4'd3) begin
        errors++;
        $display("FAIL clr_pre: sc=%0d expected 3", sc);
      end
      cycle(0, 0, 1, 0, 0);
      checks++;
      if (sc !== 4'd0 || instr_cnt !== 16'(k) || overrun !== 1'b0 || running !== 1'b1) begin
        errors++;
        $display("FAIL clr: sc=%0d cnt=%0d ovr=%0b run=%0b expected sc=0 cnt=%0d ovr=0 run=1",
                 sc, instr_cnt, overrun, running, k);
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_sc[4] = '{4'd2, 4'd2, 4'd0, 4'd0};
    logic [15:0] exp_cnt[4] = '{16'd0, 16'd0, 16'd1, 16'd1};
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, (i == 2), 1, 0);
      checks++;
      if (sc !== exp_sc[i] || instr_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL stall%0d: sc=%0d cnt=%0d expected sc=%0d cnt=%0d",
                 i, sc, instr_cnt, exp_sc[i], exp_cnt[i]);
      end
    end
  endtask

  task automatic test_halt();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    checks++;
    if (sc !== 4'd2 || running !== 1'b1) begin
      errors++;
      $display("FAIL halting_enter: sc=%0d run=%0b expected sc=2 run=1", sc, running);
    end
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (sc !== 4'd4 || running !== 1'b1) begin
      errors++;
      $display("FAIL halting_count: sc=%0d run=%0b expected sc=4 run=1", sc, running);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (sc !== 4'd0 || running !== 1'b0 || instr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL halt_done: sc=%0d run=%0b cnt=%0d expected sc=0 run=0 cnt=1", sc, running, instr_cnt);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (sc !== 4'd0 || running !== 1'b0 || instr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL idle_ignore: sc=%0d run=%0b cnt=%0d expected sc=0 run=0 cnt=1", sc, running, instr_cnt);
    end
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (sc !== 4'd1 || running !== 1'b1) begin
      errors++;
      $display("FAIL restart: sc=%0d run=%0b expected sc=1 run=1", sc, running);
    end
  endtask

  task automatic test_overrun_clr();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (7) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (overrun !== 1'b1 || sc !== 4'd0) begin
      errors++;
      $display("FAIL ovr_set_prio: ovr=%0b sc=%0d expected ovr=1 sc=0", overrun, sc);
    end
    cycle(0, 0, 0, 0, 1);
    checks++;
    if (overrun !== 1'b0 || instr_cnt !== 16'd0) begin
      errors++;
      $display("FAIL ovr_clr: ovr=%0b cnt=%0d expected ovr=0 cnt=0", overrun, instr_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0);
    repeat (5) cycle(0, 0, 0, 0, 0);
    checks++;
    if (sc !== 4'd5 || instr_cnt !== 16'd1) begin
      errors++;
      $display("FAIL pre_reset: sc=%0d cnt=%0d expected sc=5 cnt=1", sc, instr_cnt);
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (sc !== 4'd0 || running !== 1'b0 || instr_cnt !== 16'd0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: sc=%0d run=%0b cnt=%0d ovr=%0b expected all 0",
               sc, running, instr_cnt, overrun);
    end
    rst_n = 1'b1;
    cycle(1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (running !== 1'b0 || sc !== 4'd0) begin
      errors++;
      $display("FAIL start_halt_idle: run=%0b sc=%0d expected run=0 sc=0", running, sc);
    end
  endtask

  task automatic test_cnt_wrap();
    do_reset();
    cycle(1, 0, 0, 0, 0);
    repeat (65535) cycle(0, 0, 1, 0, 0);
    checks++;
    if (instr_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL cnt_full: cnt=%0d expected 65535", instr_cnt);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (instr_cnt !== 16'd0 || overrun !== 1'b0 || running !== 1'b1) begin
      errors++;
      $display("FAIL cnt_wrap: cnt=%0d ovr=%0b run=%0b expected cnt=0 ovr=0 run=1", instr_cnt, overrun, running);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 99) < 25, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10);
      checks++;
      if (sc !== 4'(m_sc) || running !== (m_mode != 0) || overrun !== m_ovr || instr_cnt !== 16'(m_cnt)) begin
        errors++;
        $display("FAIL random%0d: sc=%0d run=%0b ovr=%0b cnt=%0d expected sc=%0d run=%0b ovr=%0b cnt=%0d",
                 i, sc, running, overrun, instr_cnt, m_sc, (m_mode != 0), m_ovr, m_cnt);
      end
`ifdef SC_ONEHOT_OUT_EN
      checks++;
      if (t_reg !== (8'd1 << m_sc)) begin
        errors++;
        $display("FAIL onehot%0d: t_reg=%b expected bit %0d", i, t_reg, m_sc);
      end
`endif
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_count_wrap();
    test_sc_clr();
    test_stall();
    test_halt();
    test_overrun_clr();
    test_async_reset();
    test_random();
    test_cnt_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sc_sequence_counter.md
Name: sc_sequence_counter

Overview:
- Timing-step source for the control unit; sits directly upstream of the SC-to-Ti timing decoder.
- Drives the 4-bit sequence counter SC, which the decoder turns into one-hot T0..T7 timing signals.
- Provides run/halt control (start flip-flop), end-of-instruction clear, memory-wait stall, step-overrun detection and a retired-instruction count.

Parameters:
- SC_W, 4: sequence counter width.
- MAX_T, 7: last timing step the decoder decodes. SC never exceeds MAX_T; valid range 1..2^SC_W-1.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level/pulse; requests run while idle.
- halt  input  1  requests stop at the end of the current instruction.
- sc_clr  input  1  end of instruction from control logic; SC returns to 0.
- stall  input  1  memory wait; holds SC at its current value.
- ovr_clr  input  1  clears the sticky overrun flag.
- SC  output  SC_W  sequence counter value, feeds the timing decoder.
- running  output  1  high when the state is not IDLE.
- overrun  output  1  sticky; set when SC wrapped from MAX_T without sc_clr.
- instr_cnt  output  CNT_W  number of sc_clr events accepted while not IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): SC=0, state=IDLE, running=0, overrun=0, instr_cnt=0. Reset asserted mid-instruction aborts immediately; no count is retained.
- All outputs are registered. running is decoded from the state register.
- States:
  - IDLE: SC held at 0. sc_clr, stall and wrap are ignored.
    - start=1 and halt=0: go to RUN next edge. SC stays 0 on that edge; the first increment happens one edge after entering RUN.
    - start=1 and halt=1 together: stay IDLE.
  - RUN, per edge, priority order:
    - sc_clr: SC<=0, instr_cnt<=instr_cnt+1.
    - else stall: hold SC.
    - else SC==MAX_T: SC<=0, overrun<=1.
    - else SC<=SC+1.
    - halt=1: go to HALTING. If sc_clr is also 1 on the same edge, go directly to IDLE instead.
    - start is ignored.
  - HALTING: SC, instr_cnt and overrun update exactly as in RUN.
    - On sc_clr: SC<=0, instr_cnt increments, go to IDLE.
    - halt and start are ignored.
- Overrun flag:
  - Set has priority over ovr_clr on the same edge.
  - ovr_clr with no set: overrun<=0 next edge.
  - Wrap does not increment instr_cnt.
- instr_cnt wraps modulo 2^CNT_W: all-ones + 1 = 0, with no flag.
- Arithmetic is unsigned SC_W bits. Since MAX_T ≤ 2^SC_W-1, SC+1 never overflows the register.
- stall and sc_clr together: sc_clr wins.

Optional Feature:
- SC_ONEHOT_OUT_EN defined:
  - Adds output T_reg [MAX_T:0], registered one-hot of the next SC value, aligned with SC (same edge).
  - T_reg is 1 (bit 0) in reset and IDLE.
  - Lets timing-critical consumers bypass the combinational decoder.
- SC_ONEHOT_OUT_EN undefined: port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then start pulse, no sc_clr/stall → running=1 one edge after start; SC sequence 0,1,2,…,7,0 on successive edges; overrun=1 on the edge SC returns 0 from 7.
- In RUN, sc_clr asserted when SC=3 → next SC=0, instr_cnt 0→1, overrun stays 0; repeat 3 times → instr_cnt=3.
- stall held 4 cycles at SC=2, with sc_clr pulsed during the 3rd stall cycle → SC holds 2 for 2 edges, then 0; instr_cnt increments once.
- halt pulsed at SC=1, sc_clr at SC=4 → HALTING entered next edge, SC keeps counting 2,3,4; after sc_clr SC=0, running=0, instr_cnt+1; later start restarts from SC=0.
- Overrun set and ovr_clr on the same edge (SC=7 wrap) → overrun=1; ovr_clr alone next cycle → overrun=0.
- rst_n dropped asynchronously mid-edge-window at SC=5 in RUN → SC=0, running=0, instr_cnt=0 immediately, without waiting for clk; start with halt in IDLE → remains IDLE.
